alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single-cycle 16-bit ALU between two requesters, port 0 and port 1, such as the execute stage and an address-generation unit.
- Arbitrates round-robin, registers the winner's operands into the ALU inputs, captures the result, and returns it on the winner's response port.
- Handshakes are valid/ready on both the request and response sides. One operation is in flight at a time.

Parameters:
- DATA_W, 16, operand and result width.
- SEL_W, 3, ALU operation select width.
- SHAMT_W, 4, shift amount width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid_0 / req_valid_1  in  1  request present
- req_ready_0 / req_ready_1  out  1  request accepted this cycle
- req_a_0 / req_a_1  in  DATA_W  operand A
- req_b_0 / req_b_1  in  DATA_W  operand B
- req_sel_0 / req_sel_1  in  SEL_W  ALU operation
- req_shamt_0 / req_shamt_1  in  SHAMT_W  shift amount
- resp_valid_0 / resp_valid_1  out  1  result available
- resp_ready_0 / resp_ready_1  in  1  result consumed
- resp_data  out  DATA_W  result, shared by both ports
- resp_carry  out  1  carry flag, shared
- alu_a, alu_b  out  DATA_W  to ALU inputs A, B
- alu_sel  out  SEL_W  to ALU select
- alu_shamt  out  SHAMT_W  to ALU shift amount
- alu_out  in  DATA_W  ALU result
- alu_carry  in  1  ALU carry flag
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=1 (port 0 wins first), owner=0.
  - alu_a/alu_b/alu_sel/alu_shamt=0; resp_data=0, resp_carry=0.
  - All req_ready and resp_valid low; busy=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid port, or, when both are valid, the port other than last_grant.
  - req_ready_<grant>=1 combinationally; the non-granted port's ready stays 0.
  - On the accepting edge: latch that port's a/b/sel/shamt into alu_* registers, owner=grant, last_grant=grant, go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - The ALU is combinational on the registered alu_* values.
  - At the edge: resp_data<=alu_out, resp_carry<=alu_carry, go to RESP.
- RESP:
  - resp_valid_<owner>=1; the other port's resp_valid=0.
  - resp_data and resp_carry are held stable.
  - When resp_ready_<owner>=1 at an edge, go to IDLE; resp_valid drops the next cycle.
  - resp_ready on the non-owner port is ignored.
- Latency: request accepted at edge E0 gives resp_valid high after E1, two cycles. Minimum issue interval is 3 cycles: accept, execute, respond with immediate ready.
- No request is accepted in EXEC or RESP; req_ready is 0 in both. Requesters hold valid and payload until ready.
- Arithmetic: the block does not modify the ALU result or carry.
  - resp_carry is the ALU's carry, which is the carry of A+B for every operation, including SUB and LSL.
  - Results wrap modulo 2^16.
- Boundary cases:
  - Both ports valid on back-to-back transactions: grants strictly alternate 0,1,0,1.
  - A single port requesting continuously is granted every transaction; last_grant then always equals that port.
  - A requester dropping valid before ready has no effect; nothing is latched.
  - resp_ready held low: stay in RESP indefinitely and hold all outputs.
  - Reset asserted in EXEC or RESP: the transaction is discarded and no response is issued.
  - alu_* registers hold their last value while in IDLE; they are not cleared.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
  - ALU op constants: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, NAND=6, LSL=7.
  - Width constants DATA_W, SEL_W, SHAMT_W.
- One natural sub-module: rr_arb2, a 2-input round-robin grant.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant index and grant_valid.
  - Purely combinational; last_grant is stored in alu_arbiter.

Test Plan:
- Port 0 ADD, a=16'hFFFF, b=16'h0001 -> resp_valid_0 two cycles after accept, resp_data=16'h0000, resp_carry=1; resp_valid_1 stays 0.
- Port 1 SUB, a=5, b=7 -> resp_data=16'hFFFE, resp_carry=0; port 1 LSL, a=16'h0003, shamt=4 -> resp_data=16'h0030.
- Both ports valid continuously for 4 transactions (port 0 NAND 16'hF0F0,16'hFF00; port 1 XOR 16'h00FF,16'h0F0F) -> grants 0,1,0,1; responses 16'h0FFF and 16'h0FF0 on the correct port each time.
- resp_ready_0 held low for 5 cycles in RESP -> resp_valid_0 stays high, resp_data stable, req_ready_1 stays 0 despite req_valid_1=1; port 1 is granted in the cycle after the release edge.
- rst_n pulsed low during EXEC of port 0 OR 16'h1234,16'h4321 -> all outputs reset immediately, no resp_valid after release, port 0 granted first on its next request.
- busy checked against state every cycle; the ready/valid protocol is asserted throughout:
  - no resp_valid on a non-owner port;
  - no req_ready outside IDLE;
  - resp_data is constant while resp_valid is high and ready is low.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared widths, FSM encoding and ALU op codes for the ALU arbiter.
package alu_arbiter_pkg;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 3;
    localparam int SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [SEL_W-1:0] OP_ADD  = 3'd0;
    localparam logic [SEL_W-1:0] OP_SUB  = 3'd1;
    localparam logic [SEL_W-1:0] OP_AND  = 3'd2;
    localparam logic [SEL_W-1:0] OP_OR   = 3'd3;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'd4;
    localparam logic [SEL_W-1:0] OP_NOR  = 3'd5;
    localparam logic [SEL_W-1:0] OP_NAND = 3'd6;
    localparam logic [SEL_W-1:0] OP_LSL  = 3'd7;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: combinational two-input round-robin grant.
// The caller stores last_grant; on contention the other port wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);
    assign grant_valid = |req;
    assign grant       = (req == 2'b11) ? ~last_grant : req[1];
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two valid/ready requesters,
// one operation in flight, round-robin on contention.
module alu_arbiter #(
    parameter int DATA_W  = alu_arbiter_pkg::DATA_W,
    parameter int SEL_W   = alu_arbiter_pkg::SEL_W,
    parameter int SHAMT_W = alu_arbiter_pkg::SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid_0,
    input  logic               req_valid_1,
    output logic               req_ready_0,
    output logic               req_ready_1,
    input  logic [DATA_W-1:0]  req_a_0,
    input  logic [DATA_W-1:0]  req_a_1,
    input  logic [DATA_W-1:0]  req_b_0,
    input  logic [DATA_W-1:0]  req_b_1,
    input  logic [SEL_W-1:0]   req_sel_0,
    input  logic [SEL_W-1:0]   req_sel_1,
    input  logic [SHAMT_W-1:0] req_shamt_0,
    input  logic [SHAMT_W-1:0] req_shamt_1,
    output logic               resp_valid_0,
    output logic               resp_valid_1,
    input  logic               resp_ready_0,
    input  logic               resp_ready_1,
    output logic [DATA_W-1:0]  resp_data,
    output logic               resp_carry,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    output logic [SHAMT_W-1:0] alu_shamt,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_carry,
    output logic               busy
);
    import alu_arbiter_pkg::*;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant;
    logic   grant_valid;
    logic   accept;

    rr_arb2 u_arb (
        .req         ({req_valid_1, req_valid_0}),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    assign accept       = (state == IDLE) && grant_valid;
    assign req_ready_0  = accept && !grant;
    assign req_ready_1  = accept && grant;
    assign resp_valid_0 = (state == RESP) && !owner;
    assign resp_valid_1 = (state == RESP) && owner;
    assign busy         = (state != IDLE);

    // alu_* are deliberately left untouched in IDLE so the ALU inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            alu_shamt  <= '0;
            resp_data  <= '0;
            resp_carry <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_valid) begin
                alu_a      <= grant ? req_a_1 : req_a_0;
                alu_b      <= grant ? req_b_1 : req_b_0;
                alu_sel    <= grant ? req_sel_1 : req_sel_0;
                alu_shamt  <= grant ? req_shamt_1 : req_shamt_0;
                owner      <= grant;
                last_grant <= grant;
                state      <= EXEC;
            end
        end else if (state == EXEC) begin
            resp_data  <= alu_out;
            resp_carry <= alu_carry;
            state      <= RESP;
        end else if (state == RESP) begin
            if (owner ? resp_ready_1 : resp_ready_0)
                state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural ALU
// and a negedge protocol monitor.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid_0 = 0, req_valid_1 = 0;
    logic        req_ready_0, req_ready_1;
    logic [15:0] req_a_0 = 0, req_a_1 = 0, req_b_0 = 0, req_b_1 = 0;
    logic [2:0]  req_sel_0 = 0, req_sel_1 = 0;
    logic [3:0]  req_shamt_0 = 0, req_shamt_1 = 0;
    logic        resp_valid_0, resp_valid_1;
    logic        resp_ready_0 = 0, resp_ready_1 = 0;
    logic [15:0] resp_data;
    logic        resp_carry;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic [3:0]  alu_shamt;
    logic        alu_carry;
    logic        busy;
    logic [16:0] sum;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_sel_0(req_sel_0), .req_sel_1(req_sel_1),
        .req_shamt_0(req_shamt_0), .req_shamt_1(req_shamt_1),
        .resp_valid_0(resp_valid_0), .resp_valid_1(resp_valid_1),
        .resp_ready_0(resp_ready_0), .resp_ready_1(resp_ready_1),
        .resp_data(resp_data), .resp_carry(resp_carry),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_shamt(alu_shamt),
        .alu_out(alu_out), .alu_carry(alu_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        sum       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_carry = sum[16];
        case (alu_sel)
            3'd0:    alu_out = sum[15:0];
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            3'd4:    alu_out = alu_a ^ alu_b;
            3'd5:    alu_out = ~(alu_a | alu_b);
            3'd6:    alu_out = ~(alu_a & alu_b);
            default: alu_out = alu_a << alu_shamt;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] sel, input logic [3:0] sh);
        if (!p) begin
            req_valid_0 = 1; req_a_0 = a; req_b_0 = b; req_sel_0 = sel; req_shamt_0 = sh;
        end else begin
            req_valid_1 = 1; req_a_1 = a; req_b_1 = b; req_sel_1 = sel; req_shamt_1 = sh;
        end
    endtask

    task automatic run_one(input bit p, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] sel, input logic [3:0] sh,
                           input logic [15:0] exp_d, input logic exp_c);
        drive(p, a, b, sel, sh);
        #1;
        chk("req_ready_own", p ? req_ready_1 : req_ready_0, 1);
        chk("req_ready_other", p ? req_ready_0 : req_ready_1, 0);
        tick();
        req_valid_0 = 0; req_valid_1 = 0;
        chk("exec_busy", busy, 1);
        chk("exec_alu_a", alu_a, a);
        chk("exec_no_resp", resp_valid_0 | resp_valid_1, 0);
        tick();
        chk("resp_valid_own", p ? resp_valid_1 : resp_valid_0, 1);
        chk("resp_valid_other", p ? resp_valid_0 : resp_valid_1, 0);
        chk("resp_data", resp_data, exp_d);
        chk("resp_carry", resp_carry, exp_c);
        if (p) resp_ready_1 = 1; else resp_ready_0 = 1;
        tick();
        resp_ready_0 = 0; resp_ready_1 = 0;
        chk("done_valid", resp_valid_0 | resp_valid_1, 0);
        chk("done_busy", busy, 0);
    endtask

    // Protocol monitor: one owner, no ready while busy, data held while stalled.
    logic        hold_prev = 0;
    logic [15:0] data_prev = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("mon_one_owner", resp_valid_0 & resp_valid_1, 0);
            chk("mon_ready_idle", (req_ready_0 | req_ready_1) & busy, 0);
            chk("mon_valid_busy", (resp_valid_0 | resp_valid_1) & ~busy, 0);
            if (hold_prev) chk("mon_data_stable", resp_data, data_prev);
            hold_prev = (resp_valid_0 & ~resp_ready_0) | (resp_valid_1 & ~resp_ready_1);
            data_prev = resp_data;
        end else begin
            hold_prev = 0;
        end
    end

    initial begin
        #2 rst_n = 0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready_0 | req_ready_1, 0);
        chk("rst_valid", resp_valid_0 | resp_valid_1, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_carry", resp_carry, 0);
        tick(); tick();
        rst_n = 1;
        tick();

        run_one(0, 16'hFFFF, 16'h0001, 3'd0, 4'd0, 16'h0000, 1);
        run_one(1, 16'h0005, 16'h0007, 3'd1, 4'd0, 16'hFFFE, 0);
        run_one(1, 16'h0003, 16'h0000, 3'd7, 4'd4, 16'h0030, 0);

        for (int i = 0; i < 4; i++) begin
            automatic bit g = i[0];
            drive(0, 16'hF0F0, 16'hFF00, 3'd6, 4'd0);
            drive(1, 16'h00FF, 16'h0F0F, 3'd4, 4'd0);
            #1;
            chk("alt_ready_0", req_ready_0, !g);
            chk("alt_ready_1", req_ready_1, g);
            tick();
            tick();
            chk("alt_valid_0", resp_valid_0, !g);
            chk("alt_valid_1", resp_valid_1, g);
            chk("alt_data", resp_data, g ? 16'h0FF0 : 16'h0FFF);
            chk("alt_carry", resp_carry, !g);
            if (g) resp_ready_1 = 1; else resp_ready_0 = 1;
            tick();
            resp_ready_0 = 0; resp_ready_1 = 0;
        end
        req_valid_0 = 0; req_valid_1 = 0;

        drive(0, 16'h0001, 16'h0002, 3'd0, 4'd0);
        tick();
        req_valid_0 = 0;
        drive(1, 16'hFF0F, 16'h0FF0, 3'd2, 4'd0);
        resp_ready_1 = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid_0", resp_valid_0, 1);
            chk("stall_data", resp_data, 16'h0003);
            chk("stall_ready_1", req_ready_1, 0);
            tick();
        end
        resp_ready_0 = 1;
        tick();
        resp_ready_0 = 0;
        chk("release_ready_1", req_ready_1, 1);
        chk("release_valid_0", resp_valid_0, 0);
        tick();
        req_valid_1 = 0;
        tick();
        chk("p1_valid_1", resp_valid_1, 1);
        chk("p1_valid_0", resp_valid_0, 0);
        chk("p1_data", resp_data, 16'h0F00);
        chk("p1_carry", resp_carry, 1);
        tick();
        resp_ready_1 = 0;
        chk("p1_done", busy, 0);

        drive(0, 16'h1234, 16'h4321, 3'd3, 4'd0);
        tick();
        req_valid_0 = 0;
        chk("pre_rst_busy", busy, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_data", resp_data, 0);
        chk("mid_rst_valid", resp_valid_0 | resp_valid_1, 0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_resp", resp_valid_0 | resp_valid_1 | busy, 0);
        end
        run_one(0, 16'h1234, 16'h4321, 3'd3, 4'd0, 16'h5335, 0);
        drive(0, 16'h1234, 16'h4321, 3'd3, 4'd0);
        drive(1, 16'h0001, 16'h0001, 3'd0, 4'd0);
        #1;
        chk("rr_after_p0_ready_1", req_ready_1, 1);
        chk("rr_after_p0_ready_0", req_ready_0, 0);
        req_valid_0 = 0; req_valid_1 = 0;
        rst_n = 0;
        #1;
        rst_n = 1;
        drive(0, 16'h1234, 16'h4321, 3'd3, 4'd0);
        drive(1, 16'h0001, 16'h0001, 3'd0, 4'd0);
        #1;
        chk("rst_first_ready_0", req_ready_0, 1);
        chk("rst_first_ready_1", req_ready_1, 0);
        req_valid_1 = 0;
        tick();
        req_valid_0 = 0;
        tick();
        chk("rst_first_data", resp_data, 16'h5335);
        chk("rst_first_valid_0", resp_valid_0, 1);
        resp_ready_0 = 1;
        tick();
        resp_ready_0 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
